// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// instruction classes and datapath select codes.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_TRAP
   } state_t;

   typedef enum logic [3:0] {
      CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILL
   } cls_t;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_JALR   = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   function automatic cls_t opcode_class(input logic [6:0] opc);
      cls_t c;
      case (opc)
         OPC_R:      c = CLS_R;
         OPC_I:      c = CLS_I;
         OPC_LOAD:   c = CLS_LOAD;
         OPC_STORE:  c = CLS_STORE;
         OPC_BRANCH: c = CLS_BRANCH;
         OPC_JAL:    c = CLS_JAL;
         OPC_JALR:   c = CLS_JALR;
         OPC_LUI:    c = CLS_LUI;
         OPC_AUIPC:  c = CLS_AUIPC;
         default:    c = CLS_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_ctrl.sv
// ALU operation select from the latched instruction class and funct fields.
module riscv_alu_ctrl
   import riscv_ctrl_pkg::*;
(
   input  cls_t       cls,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_op
);

   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      alu_op = ALU_ADD;
      case (cls)
         CLS_R, CLS_I: begin
            case (funct3)
               // Immediate forms have no SUBI; funct7[5] only selects SRAI.
               3'b000:  alu_op = (cls == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         CLS_LUI:    alu_op = ALU_PASSB;
         CLS_BRANCH: alu_op = ALU_SUB;
         default:    alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback,
// owns the memory handshake, counts retired instructions and traps.
module riscv_multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             br_taken,
   input  logic             mem_ready,
   input  logic             trap_clr,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic [3:0]       alu_op,
   output logic [2:0]       imm_type,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   state_t      state;
   state_t      fetch_or_idle;
   cls_t        cls;
   cls_t        dec_cls;
   logic [31:0] to_cnt;
   logic        timeout_hit;
   logic [3:0]  alu_op_w;

   assign dec_cls       = opcode_class(opcode);
   assign fetch_or_idle = run ? ST_FETCH : ST_IDLE;
   // Fires on the TIMEOUT-th consecutive stalled request cycle.
   assign timeout_hit   = (TIMEOUT != 0) && !mem_ready && (to_cnt == TIMEOUT - 1);

   riscv_alu_ctrl u_alu_ctrl (
      .cls    (cls),
      .funct3 (funct3),
      .funct7 (funct7),
      .alu_op (alu_op_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cls        <= CLS_R;
         instret    <= '0;
         trap       <= 1'b0;
         trap_cause <= CAUSE_NONE;
         to_cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: if (run) state <= ST_FETCH;
            ST_FETCH: begin
               if (mem_ready) begin
                  to_cnt <= '0;
                  state  <= ST_DECODE;
               end else if (timeout_hit) begin
                  to_cnt     <= '0;
                  state      <= ST_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_TIMEOUT;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
            ST_DECODE: begin
               cls <= dec_cls;
               if (dec_cls == CLS_ILL) begin
                  state      <= ST_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_ILLEGAL;
               end else begin
                  state <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               case (cls)
                  CLS_BRANCH, CLS_JAL, CLS_JALR: begin
                     state   <= fetch_or_idle;
                     instret <= instret + CNT_W'(1);
                  end
                  CLS_LOAD, CLS_STORE: state <= ST_MEM;
                  default:             state <= ST_WRITEBACK;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  to_cnt <= '0;
                  if (cls == CLS_STORE) begin
                     state   <= fetch_or_idle;
                     instret <= instret + CNT_W'(1);
                  end else begin
                     state <= ST_WRITEBACK;
                  end
               end else if (timeout_hit) begin
                  to_cnt     <= '0;
                  state      <= ST_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_TIMEOUT;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
            ST_WRITEBACK: begin
               state   <= fetch_or_idle;
               instret <= instret + CNT_W'(1);
            end
            ST_TRAP: begin
               if (trap_clr) begin
                  state      <= ST_IDLE;
                  trap       <= 1'b0;
                  trap_cause <= CAUSE_NONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      imm_type  = IMM_I;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      case (state)
         ST_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
         end
         ST_DECODE: begin
            // Control-flow instructions settle the PC themselves in EXECUTE.
            case (dec_cls)
               CLS_ILL, CLS_BRANCH, CLS_JAL, CLS_JALR: ;
               default: pc_we = 1'b1;
            endcase
         end
         ST_EXECUTE: begin
            alu_op = alu_op_w;
            case (cls)
               CLS_I, CLS_LOAD: begin
                  alu_src_b = 1'b1;
                  imm_type  = IMM_I;
               end
               CLS_STORE: begin
                  alu_src_b = 1'b1;
                  imm_type  = IMM_S;
               end
               CLS_LUI: begin
                  alu_src_b = 1'b1;
                  imm_type  = IMM_U;
               end
               CLS_AUIPC: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
                  imm_type  = IMM_U;
               end
               CLS_BRANCH: begin
                  imm_type = IMM_B;
                  pc_we    = 1'b1;
                  pc_sel   = br_taken ? PC_TARGET : PC_PLUS4;
               end
               CLS_JAL: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
                  imm_type  = IMM_J;
                  pc_we     = 1'b1;
                  pc_sel    = PC_TARGET;
                  reg_we    = 1'b1;
                  wb_sel    = WB_PC4;
               end
               CLS_JALR: begin
                  alu_src_b = 1'b1;
                  imm_type  = IMM_I;
                  pc_we     = 1'b1;
                  pc_sel    = PC_JALR;
                  reg_we    = 1'b1;
                  wb_sel    = WB_PC4;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (cls == CLS_STORE);
         end
         ST_WRITEBACK: begin
            reg_we = 1'b1;
            wb_sel = (cls == CLS_LOAD) ? WB_MEM : WB_ALU;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl with a 4-bit retire counter and a
// 4-cycle memory timeout.
module tb_riscv_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, run, br_taken, mem_ready, trap_clr;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_a, alu_src_b, reg_we, trap;
   logic [1:0] pc_sel, wb_sel, trap_cause;
   logic [3:0] alu_op, instret;
   logic [2:0] imm_type;
   logic [18:0] ctl;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   riscv_multicycle_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .br_taken(br_taken), .mem_ready(mem_ready), .trap_clr(trap_clr),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_type(imm_type), .reg_we(reg_we), .wb_sel(wb_sel),
      .instret(instret), .trap(trap), .trap_cause(trap_cause)
   );

   assign ctl = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_a, alu_src_b,
                 alu_op, imm_type, reg_we, wb_sel};

   function automatic logic [18:0] mk(input logic mreq, input logic mwe, input logic asel,
                                      input logic irwe, input logic pcwe, input logic [1:0] pcsel,
                                      input logic srca, input logic srcb, input logic [3:0] aop,
                                      input logic [2:0] imm, input logic regwe, input logic [1:0] wbs);
      return {mreq, mwe, asel, irwe, pcwe, pcsel, srca, srcb, aop, imm, regwe, wbs};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic set_ins(input logic [31:0] ins);
      opcode = ins[6:0];
      funct3 = ins[14:12];
      funct7 = ins[31:25];
   endtask

   // 16 back-to-back ALU-class instructions used for the counter wrap run.
   logic [6:0] lp_opc [16] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33,
                               7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h13, 7'h37, 7'h17};
   logic [2:0] lp_f3  [16] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5,
                               3'd6, 3'd7, 3'd0, 3'd5, 3'd5, 3'd6, 3'd0, 3'd0};
   logic [6:0] lp_f7  [16] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20,
                               7'h00, 7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
   logic [3:0] lp_aop [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                               4'd8, 4'd9, 4'd0, 4'd7, 4'd6, 4'd8, 4'd10, 4'd0};
   logic       lp_sa  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
   logic       lp_sb  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
   logic [2:0] lp_imm [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                               3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3};

   initial begin
      rst_n = 1'b0; run = 1'b0; br_taken = 1'b0; mem_ready = 1'b0; trap_clr = 1'b0;
      opcode = '0; funct3 = '0; funct7 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ctl", ctl, 0);
      chk("rst_instret", instret, 0);
      chk("rst_trap", trap, 0);
      chk("rst_cause", trap_cause, 0);
      @(negedge clk); rst_n = 1'b1;

      // ADD x3,x1,x2 with memory always ready
      @(negedge clk); run = 1'b1; mem_ready = 1'b1; set_ins(32'h002081B3); #1;
      chk("add_idle", ctl, 0);
      @(negedge clk); #1; chk("add_fetch", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
      @(negedge clk); #1; chk("add_decode", ctl, mk(0,0,0,0,1,0,0,0,0,0,0,0));
      @(negedge clk); #1; chk("add_exec", ctl, mk(0,0,0,0,0,0,0,0,0,0,0,0));
      @(negedge clk); run = 1'b0; #1;
      chk("add_wb", ctl, mk(0,0,0,0,0,0,0,0,0,0,1,0));
      chk("add_instret0", instret, 0);
      @(negedge clk); #1;
      chk("add_instret1", instret, 1);
      chk("add_idle_after", ctl, 0);

      // LW x5,8(x1) with three stall cycles in FETCH and in MEM
      @(negedge clk); run = 1'b1; mem_ready = 1'b0; set_ins(32'h0080A283);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1; chk("lw_fetch_stall", ctl, mk(1,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk); mem_ready = 1'b1; #1; chk("lw_fetch_ack", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
      @(negedge clk); mem_ready = 1'b0; #1; chk("lw_decode", ctl, mk(0,0,0,0,1,0,0,0,0,0,0,0));
      @(negedge clk); #1; chk("lw_exec", ctl, mk(0,0,0,0,0,0,0,1,0,0,0,0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1; chk("lw_mem_stall", ctl, mk(1,0,1,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk); mem_ready = 1'b1; #1; chk("lw_mem_ack", ctl, mk(1,0,1,0,0,0,0,0,0,0,0,0));
      @(negedge clk); mem_ready = 1'b0; run = 1'b0; #1;
      chk("lw_wb", ctl, mk(0,0,0,0,0,0,0,0,0,0,1,1));
      @(negedge clk); #1;
      chk("lw_instret", instret, 2);
      chk("lw_no_trap", trap, 0);

      // BEQ taken, then not taken, back to back
      @(negedge clk); run = 1'b1; mem_ready = 1'b1; br_taken = 1'b1; set_ins(32'h00208463);
      @(negedge clk); #1; chk("beq_fetch", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
      @(negedge clk); #1; chk("beq_decode", ctl, 0);
      @(negedge clk); #1;
      chk("beq_t_pcwe", pc_we, 1);
      chk("beq_t_pcsel", pc_sel, 1);
      chk("beq_t_regwe", reg_we, 0);
      @(negedge clk); br_taken = 1'b0; #1;
      chk("beq_instret", instret, 3);
      chk("beq2_fetch", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
      @(negedge clk); #1; chk("beq2_decode", ctl, 0);
      @(negedge clk); run = 1'b0; #1;
      chk("beq_n_pcwe", pc_we, 1);
      chk("beq_n_pcsel", pc_sel, 0);
      chk("beq_n_regwe", reg_we, 0);
      @(negedge clk); #1;
      chk("beq2_instret", instret, 4);
      chk("beq_idle", ctl, 0);

      // Illegal opcode 0x7F
      @(negedge clk); run = 1'b1; set_ins(32'h0000007F);
      @(negedge clk); #1; chk("ill_fetch", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
      @(negedge clk); run = 1'b0; #1;
      chk("ill_decode", ctl, 0);
      chk("ill_pre_trap", trap, 0);
      @(negedge clk); #1;
      chk("ill_trap", trap, 1);
      chk("ill_cause", trap_cause, 1);
      chk("ill_trap_ctl", ctl, 0);
      @(negedge clk); trap_clr = 1'b1; #1;
      chk("ill_sticky", trap, 1);
      @(negedge clk); trap_clr = 1'b0; #1;
      chk("ill_clr_trap", trap, 0);
      chk("ill_clr_cause", trap_cause, 0);
      chk("ill_instret", instret, 4);

      // Memory never answers in FETCH
      @(negedge clk); run = 1'b1; mem_ready = 1'b0; set_ins(32'h002081B3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk("to_req", mem_req, 1);
         chk("to_no_trap", trap, 0);
      end
      @(negedge clk); run = 1'b0; #1;
      chk("to_req_drop", mem_req, 0);
      chk("to_trap", trap, 1);
      chk("to_cause", trap_cause, 2);
      @(negedge clk); trap_clr = 1'b1;
      @(negedge clk); trap_clr = 1'b0; #1;
      chk("to_clr_trap", trap, 0);
      chk("to_clr_ctl", ctl, 0);

      // Async reset clears the counter, then 16 retirements wrap it
      @(negedge clk); rst_n = 1'b0; #1;
      chk("rst2_instret", instret, 0);
      @(negedge clk); rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         opcode = lp_opc[i]; funct3 = lp_f3[i]; funct7 = lp_f7[i];
         #1;
         chk("wrap_count", instret, i);
         chk("wrap_fetch", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
         @(negedge clk); #1; chk("wrap_decode", ctl, mk(0,0,0,0,1,0,0,0,0,0,0,0));
         @(negedge clk); #1;
         chk("wrap_exec", ctl, mk(0,0,0,0,0,0,lp_sa[i],lp_sb[i],lp_aop[i],lp_imm[i],0,0));
         @(negedge clk); #1; chk("wrap_wb", ctl, mk(0,0,0,0,0,0,0,0,0,0,1,0));
      end

      // SW x2,4(x1): one full store, then reset in the middle of a second one
      @(negedge clk); set_ins({7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}); #1;
      chk("wrap_zero", instret, 0);
      @(negedge clk); #1; chk("sw_decode", ctl, mk(0,0,0,0,1,0,0,0,0,0,0,0));
      @(negedge clk); #1; chk("sw_exec", ctl, mk(0,0,0,0,0,0,0,1,0,1,0,0));
      @(negedge clk); #1; chk("sw_mem", ctl, mk(1,1,1,0,0,0,0,0,0,0,0,0));
      @(negedge clk); #1;
      chk("sw_instret", instret, 1);
      chk("sw2_fetch", ctl, mk(1,0,0,1,0,0,0,0,0,0,0,0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("sw2_mem", ctl, mk(1,1,1,0,0,0,0,0,0,0,0,0));
      @(negedge clk); rst_n = 1'b0; #1;
      chk("midmem_rst_ctl", ctl, 0);
      chk("midmem_rst_instret", instret, 0);
      chk("midmem_rst_trap", trap, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
